// File: rtl/float_addsub_pipe_if.sv
// Operand/result bundle for float_addsub_pipe.
// The master side issues operand pairs and collects results; the slave side is the adder.
interface float_addsub_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         op_sub;
   logic [W-1:0] adata;
   logic [W-1:0] bdata;
   logic         out_valid;
   logic [W-1:0] cdata;
   logic [3:0]   flags;

   modport master (
      output in_valid, op_sub, adata, bdata,
      input  out_valid, cdata, flags
   );

   modport slave (
      input  in_valid, op_sub, adata, bdata,
      output out_valid, cdata, flags
   );
endinterface

// File: rtl/float_addsub_pipe.sv
// Fully pipelined floating-point adder/subtractor, round-to-nearest-even, flush-to-zero.
// Stages: S1 unpack/swap, S2 align, S3 add, S4 normalise, S5 round, then pack/specials
// into the output register. Five cycles from operand sample to out_valid.
module float_addsub_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic               clock,
   input  logic               rst_n,
   float_addsub_pipe_if.slave bus
);
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
   localparam int SIG_W = MAN_W + 4;               // hidden + mantissa + guard/round/sticky
   localparam int E_W   = EXP_W + 2;               // signed working exponent
   localparam int LZ_W  = $clog2(SIG_W + 1);

   localparam logic [EXP_W-1:0]      EXP_ONES = '1;
   localparam logic signed [E_W-1:0] EXP_INF  = E_W'(2 * BIAS + 1);
   localparam logic signed [E_W-1:0] EXP_ZERO = '0;
   localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // Special-case result decided at unpack time and carried alongside the datapath.
   typedef struct packed {
      logic         hit;
      logic         nan;
      logic [W-1:0] word;
   } special_t;

   function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
      lzc = LZ_W'(SIG_W);
      for (int i = 0; i < SIG_W; i++)
         if (v[i]) lzc = LZ_W'(SIG_W - 1 - i);
   endfunction

   // ---------------- valid pipeline ----------------
   logic [5:1] vld;
   logic       out_valid_q;
   logic [W-1:0] cdata_q;
   logic [3:0]   flags_q;

   // ---------------- S1 unpack / swap ----------------
   logic             sign_a, sign_b, inf_a, inf_b, zero_a, zero_b, a_in_x;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] man_a, man_b;
   special_t         sp_in;

   // Classify operands, fold op_sub into B's sign, and resolve infinity/zero results.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it
      // unassigned; an unassigned path would infer a latch.
      sp_in  = '0;
      sign_a = bus.adata[W-1];
      exp_a  = bus.adata[W-2:MAN_W];
      man_a  = bus.adata[MAN_W-1:0];
      sign_b = bus.bdata[W-1] ^ bus.op_sub;
      exp_b  = bus.bdata[W-2:MAN_W];
      man_b  = bus.bdata[MAN_W-1:0];
      inf_a  = (exp_a == EXP_ONES);
      inf_b  = (exp_b == EXP_ONES);
      zero_a = (exp_a == '0);
      zero_b = (exp_b == '0);
      a_in_x = (bus.adata[W-2:0] >= bus.bdata[W-2:0]);

      if (inf_a && inf_b) begin
         sp_in.hit = 1'b1;
         if (sign_a != sign_b) begin
            sp_in.nan  = 1'b1;
            sp_in.word = QNAN;
         end else begin
            sp_in.word = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
         end
      end else if (inf_a) begin
         sp_in.hit  = 1'b1;
         sp_in.word = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
      end else if (inf_b) begin
         sp_in.hit  = 1'b1;
         sp_in.word = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
      end else if (zero_a && zero_b) begin
         sp_in.hit  = 1'b1;
         sp_in.word = {sign_a & sign_b, {(W-1){1'b0}}};
      end else if (zero_a) begin
         sp_in.hit  = 1'b1;
         sp_in.word = {sign_b, exp_b, man_b};
      end else if (zero_b) begin
         sp_in.hit  = 1'b1;
         sp_in.word = bus.adata;
      end
   end

   logic             s1_sign, s1_eff_sub;
   logic [EXP_W-1:0] s1_exp, s1_d;
   logic [MAN_W:0]   s1_sig_x, s1_sig_y;
   special_t         s1_sp;

   // S1 register: larger magnitude goes to the X lane (A wins ties).
   // NOTE: datapath registers carry no reset; only the valid bits and the visible
   // outputs must come up clean, and a bubble's data is never observed.
   always_ff @(posedge clock) begin
      s1_sp      <= sp_in;
      s1_eff_sub <= sign_a ^ sign_b;
      if (a_in_x) begin
         s1_sign  <= sign_a;
         s1_exp   <= exp_a;
         s1_d     <= exp_a - exp_b;
         s1_sig_x <= {~zero_a, man_a};
         s1_sig_y <= {~zero_b, man_b};
      end else begin
         s1_sign  <= sign_b;
         s1_exp   <= exp_b;
         s1_d     <= exp_b - exp_a;
         s1_sig_x <= {~zero_b, man_b};
         s1_sig_y <= {~zero_a, man_a};
      end
   end

   // ---------------- S2 align ----------------
   logic [SIG_W-1:0] y_ext, y_shift, y_lost, y_al;

   // Shift Y right by the exponent difference, collapsing lost bits into sticky.
   always_comb begin
      y_ext   = {s1_sig_y, 3'b000};
      y_shift = y_ext >> s1_d;
      y_lost  = y_ext & ~({SIG_W{1'b1}} << s1_d);
      if (int'(s1_d) >= MAN_W + 3)
         y_al = {{(SIG_W-1){1'b0}}, |s1_sig_y};
      else
         y_al = {y_shift[SIG_W-1:1], y_shift[0] | (|y_lost)};
   end

   logic             s2_sign, s2_eff_sub;
   logic [EXP_W-1:0] s2_exp;
   logic [MAN_W:0]   s2_sig_x;
   logic [SIG_W-1:0] s2_sig_y;
   special_t         s2_sp;

   // S2 register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      s2_sign    <= s1_sign;
      s2_eff_sub <= s1_eff_sub;
      s2_exp     <= s1_exp;
      s2_sig_x   <= s1_sig_x;
      s2_sig_y   <= y_al;
      s2_sp      <= s1_sp;
   end

   // ---------------- S3 add ----------------
   logic [SIG_W:0]   x_ext, y_ext2;
   logic             s3_sign;
   logic [EXP_W-1:0] s3_exp;
   logic [SIG_W:0]   s3_sum;
   special_t         s3_sp;

   assign x_ext  = {1'b0, s2_sig_x, 3'b000};
   assign y_ext2 = {1'b0, s2_sig_y};

   // S3 register: magnitude sum or difference; X >= Y so the difference is never negative.
   always_ff @(posedge clock) begin
      s3_sign <= s2_sign;
      s3_exp  <= s2_exp;
      s3_sum  <= s2_eff_sub ? (x_ext - y_ext2) : (x_ext + y_ext2);
      s3_sp   <= s2_sp;
   end

   // ---------------- S4 normalise ----------------
   logic signed [E_W-1:0] exp_s, n_exp;
   logic [SIG_W-1:0]      n_sig;
   logic [LZ_W-1:0]       lz;

   // Bring the leading one to the hidden-bit position and adjust the exponent.
   always_comb begin
      exp_s = signed'({2'b00, s3_exp});
      lz    = '0;
      if (s3_sum[SIG_W]) begin
         n_sig = {s3_sum[SIG_W:2], s3_sum[1] | s3_sum[0]};
         n_exp = exp_s + E_W'(1);
      end else begin
         lz    = lzc(s3_sum[SIG_W-1:0]);
         n_sig = s3_sum[SIG_W-1:0] << lz;
         n_exp = exp_s - E_W'(lz);
      end
   end

   logic                  s4_sign, s4_cancel;
   logic signed [E_W-1:0] s4_exp;
   logic [SIG_W-1:0]      s4_sig;
   special_t              s4_sp;

   // S4 register: a zero sum marks exact cancellation.
   always_ff @(posedge clock) begin
      s4_sign   <= s3_sign;
      s4_exp    <= n_exp;
      s4_sig    <= n_sig;
      s4_cancel <= (s3_sum == '0);
      s4_sp     <= s3_sp;
   end

   // ---------------- S5 round ----------------
   logic           g_bit, r_bit, s_bit, round_up;
   logic [MAN_W+1:0] man_rnd;

   // Round to nearest, ties to even, on the guard/round/sticky bits.
   always_comb begin
      g_bit    = s4_sig[2];
      r_bit    = s4_sig[1];
      s_bit    = s4_sig[0];
      round_up = g_bit & (r_bit | s_bit | s4_sig[3]);
      man_rnd  = {1'b0, s4_sig[SIG_W-1:3]} + (MAN_W+2)'(round_up);
   end

   logic                  s5_sign, s5_cancel, s5_inx;
   logic signed [E_W-1:0] s5_exp;
   logic [MAN_W-1:0]      s5_man;
   special_t              s5_sp;

   // S5 register: a rounding carry out of the significand renormalises by one.
   always_ff @(posedge clock) begin
      s5_sign   <= s4_sign;
      s5_cancel <= s4_cancel;
      s5_inx    <= g_bit | r_bit | s_bit;
      s5_sp     <= s4_sp;
      if (man_rnd[MAN_W+1]) begin
         s5_man <= man_rnd[MAN_W:1];
         s5_exp <= s4_exp + E_W'(1);
      end else begin
         s5_man <= man_rnd[MAN_W-1:0];
         s5_exp <= s4_exp;
      end
   end

   // ---------------- pack / specials ----------------
   logic [W-1:0] res_word;
   logic [3:0]   res_flags;

   // Select the final word: specials, cancellation, overflow, underflow, else normal.
   always_comb begin
      res_word  = {s5_sign, s5_exp[EXP_W-1:0], s5_man};
      res_flags = {3'b000, s5_inx};
      if (s5_sp.hit) begin
         res_word  = s5_sp.word;
         res_flags = {s5_sp.nan, 3'b000};
      end else if (s5_cancel) begin
         res_word  = '0;
         res_flags = '0;
      end else if (s5_exp >= EXP_INF) begin
         res_word  = {s5_sign, EXP_ONES, {MAN_W{1'b0}}};
         res_flags = 4'b0101;
      end else if (s5_exp <= EXP_ZERO) begin
         res_word  = {s5_sign, {(W-1){1'b0}}};
         res_flags = 4'b0011;
      end
   end

   // Valid pipeline and visible outputs; reset discards everything in flight.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vld         <= '0;
         out_valid_q <= 1'b0;
         cdata_q     <= '0;
         flags_q     <= '0;
      end else begin
         vld         <= {vld[4:1], bus.in_valid};
         out_valid_q <= vld[5];
         if (vld[5]) begin
            cdata_q <= res_word;
            flags_q <= res_flags;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.cdata     = cdata_q;
   assign bus.flags     = flags_q;
endmodule

// File: tb/tb_float_addsub_pipe.sv
// Self-checking bench for float_addsub_pipe: directed vector table, streaming with a
// bubble gap against an exact-arithmetic reference, mid-stream reset, and a
// single-precision instance.
module tb_float_addsub_pipe;
   logic clock;
   logic rst_n;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   float_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();
   float_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();

   float_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_dut16 (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   float_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] c;
      logic [3:0]  f;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   localparam int NS = 14;
   logic [15:0] st_a [NS];
   logic [15:0] st_b [NS];
   logic        st_s [NS];
   logic        st_v [NS];
   logic [19:0] st_r [NS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic sub);
      bus16.in_valid = v;
      bus16.adata    = a;
      bus16.bdata    = b;
      bus16.op_sub   = sub;
   endtask

   // One isolated transaction: out_valid must be low after edge N+4 and high after N+5.
   task automatic run_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] c_want, input logic [3:0] f_want);
      @(negedge clock);
      drive16(1'b1, a, b, sub);
      @(negedge clock);
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      repeat (4) @(negedge clock);
      check({name, " early"}, 32'(bus16.out_valid), 32'd0);
      @(negedge clock);
      check({name, " valid"}, 32'(bus16.out_valid), 32'd1);
      check({name, " cdata"}, 32'(bus16.cdata), 32'(c_want));
      check({name, " flags"}, 32'(bus16.flags), 32'(f_want));
   endtask

   // Exact half-precision reference for normal operands: integer sum at the smaller
   // exponent, then RNE to 11 significant bits with flush-to-zero. Returns {flags, word}.
   function automatic logic [19:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic sub);
      logic   sa, sb, rs, inx;
      int     ea, eb, emin, p, e, sh;
      longint ma, mb, s, m, q, rem, half;
      sa   = a[15];
      sb   = b[15] ^ sub;
      ea   = int'(a[14:10]);
      eb   = int'(b[14:10]);
      emin = (ea < eb) ? ea : eb;
      ma   = longint'({1'b1, a[9:0]}) << (ea - emin);
      mb   = longint'({1'b1, b[9:0]}) << (eb - emin);
      s    = (sa ? -ma : ma) + (sb ? -mb : mb);
      rs   = (s < 0);
      m    = rs ? -s : s;
      if (m == 0) return 20'h0;
      p = 0;
      for (int i = 0; i < 63; i++) if (m[i]) p = i;
      e   = emin + p - 10;
      inx = 1'b0;
      if (p > 10) begin
         sh   = p - 10;
         q    = m >> sh;
         rem  = m - (q << sh);
         half = longint'(1) << (sh - 1);
         inx  = (rem != 0);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == 2048) begin
            q = q >> 1;
            e = e + 1;
         end
      end else begin
         q = m << (10 - p);
      end
      if (e >= 31) return {4'b0101, rs, 5'h1F, 10'h000};
      if (e <= 0)  return {4'b0011, rs, 15'h0000};
      return {3'b000, inx, rs, e[4:0], q[9:0]};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000};  // 1 + 2
      vecs[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000};  // 1 - 1
      vecs[2]  = '{16'hBC00, 16'h3C00, 1'b0, 16'h0000, 4'b0000};  // -1 + 1
      vecs[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001};  // tie, even stays
      vecs[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001};  // tie, odd rounds up
      vecs[5]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101};  // overflow
      vecs[6]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000};  // inf - inf
      vecs[7]  = '{16'h7C00, 16'h4000, 1'b1, 16'h7C00, 4'b0000};  // inf - 2
      vecs[8]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000};  // 1 + 1
      vecs[9]  = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000};  // 2 - 1, left shift
      vecs[10] = '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 4'b0001};  // above half
      vecs[11] = '{16'h3C00, 16'h0400, 1'b0, 16'h3C00, 4'b0001};  // d >= MAN_W+3
      vecs[12] = '{16'hC000, 16'hC200, 1'b0, 16'hC500, 4'b0000};  // -2 + -3
      vecs[13] = '{16'hFBFF, 16'hFBFF, 1'b0, 16'hFC00, 4'b0101};  // negative overflow
      vecs[14] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b0011};  // underflow +
      vecs[15] = '{16'h0400, 16'h0401, 1'b1, 16'h8000, 4'b0011};  // underflow -
      vecs[16] = '{16'h0000, 16'h3C00, 1'b0, 16'h3C00, 4'b0000};  // zero + x
      vecs[17] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000};  // -0 + -0
      vecs[18] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0000};  // -0 - +0
      vecs[19] = '{16'h4000, 16'h7C00, 1'b1, 16'hFC00, 4'b0000};  // 2 - inf
      vecs[20] = '{16'h7C00, 16'h7C00, 1'b0, 16'h7C00, 4'b0000};  // inf + inf
      vecs[21] = '{16'h7C00, 16'h0000, 1'b0, 16'h7C00, 4'b0000};  // inf + 0
      vecs[22] = '{16'h3BFF, 16'h1000, 1'b0, 16'h3C00, 4'b0000};  // carry-out, exact
      vecs[23] = '{16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 4'b0001};  // round carries out

      for (int j = 0; j < NS; j++) begin
         int ea, eb;
         ea      = int'($urandom_range(8, 22));
         eb      = ea + int'($urandom_range(0, 6)) - 3;
         st_v[j] = (j < 8) || (j >= 10);
         st_s[j] = 1'($urandom_range(0, 1));
         st_a[j] = {1'($urandom_range(0, 1)), 5'(ea), 10'($urandom_range(0, 1023))};
         st_b[j] = {1'($urandom_range(0, 1)), 5'(eb), 10'($urandom_range(0, 1023))};
         st_r[j] = ref_add(st_a[j], st_b[j], st_s[j]);
      end

      // Reset state.
      rst_n = 1'b0;
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      bus32.in_valid = 1'b0;
      bus32.adata    = '0;
      bus32.bdata    = '0;
      bus32.op_sub   = 1'b0;
      #2;
      check("reset out_valid", 32'(bus16.out_valid), 32'd0);
      check("reset cdata", 32'(bus16.cdata), 32'd0);
      check("reset flags", 32'(bus16.flags), 32'd0);
      check("reset out_valid32", 32'(bus32.out_valid), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < NV; i++)
         run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].c, vecs[i].f);

      // Streaming: 8 pairs, 2 bubbles, 4 pairs. Input driven at iteration j shows at j+6.
      for (int cyc = 0; cyc < NS + 8; cyc++) begin
         logic exp_v;
         @(negedge clock);
         exp_v = (cyc >= 6 && cyc - 6 < NS) ? st_v[cyc-6] : 1'b0;
         check($sformatf("stream%0d valid", cyc), 32'(bus16.out_valid), 32'(exp_v));
         if (exp_v) begin
            check($sformatf("stream%0d cdata", cyc), 32'(bus16.cdata), 32'(st_r[cyc-6][15:0]));
            check($sformatf("stream%0d flags", cyc), 32'(bus16.flags), 32'(st_r[cyc-6][19:16]));
         end
         if (cyc < NS) drive16(st_v[cyc], st_a[cyc], st_b[cyc], st_s[cyc]);
         else          drive16(1'b0, 16'h0, 16'h0, 1'b0);
      end

      // Mid-stream reset: leave a non-zero result visible, then kill 3 in-flight pairs.
      run_vec("pre_reset", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         drive16(1'b1, 16'h4000 + 16'(j), 16'h3C00, 1'b0);
      end
      @(negedge clock);
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midreset out_valid", 32'(bus16.out_valid), 32'd0);
      check("midreset cdata", 32'(bus16.cdata), 32'd0);
      check("midreset flags", 32'(bus16.flags), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         check($sformatf("post_reset quiet%0d", k), 32'(bus16.out_valid), 32'd0);
      end
      run_vec("after_reset", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);

      // Single precision: 1.5 + 2.25 = 3.75.
      @(negedge clock);
      bus32.in_valid = 1'b1;
      bus32.adata    = 32'h3FC00000;
      bus32.bdata    = 32'h40100000;
      bus32.op_sub   = 1'b0;
      @(negedge clock);
      bus32.in_valid = 1'b0;
      repeat (4) @(negedge clock);
      check("sp early", 32'(bus32.out_valid), 32'd0);
      @(negedge clock);
      check("sp valid", 32'(bus32.out_valid), 32'd1);
      check("sp cdata", bus32.cdata, 32'h40700000);
      check("sp flags", 32'(bus32.flags), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
